// File: rtl/bbus_ctrl_pkg.sv
// Shared constants and types for the SNES B-bus access sequencer.
//  - Pin and level-shifter direction encodings, shared with the board top level.
//  - FSM state type.
//  - Helper used to size the phase counter.
package bbus_ctrl_pkg;

  // Pin direction encodings for the pin_bidir_8 wrappers.
  localparam logic PIN_DIR_INPUT  = 1'b0;
  localparam logic PIN_DIR_OUTPUT = 1'b1;

  // Level-shifter direction encodings.
  localparam logic LVL_DIR_INPUT  = 1'b0;
  localparam logic LVL_DIR_OUTPUT = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } bbus_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/bbus_ctrl.sv
// Single-register access sequencer for the SNES B-bus (PA/PD, /PARD, /PAWR).
// Each accepted request runs SETUP -> STROBE -> HOLD and returns to IDLE with a one-cycle
// rsp_valid_o pulse. All bus-facing outputs are registered so strobes are glitch-free, and PD
// is driven only during the SETUP/STROBE/HOLD phases of a write.
// Ports:
//  clk_i          system clock
//  reset_i        asynchronous active-high reset
//  req_valid_i    request present          req_ready_o  request accepted this cycle when high
//  req_write_i    1 = write, 0 = read      req_addr_i   B-bus register address
//  req_wdata_i    write data
//  rsp_valid_o    access complete pulse    rsp_rdata_o  read data (held across writes)
//  pard_n_o       read strobe              pawr_n_o     write strobe
//  lvl_pa_dir_o   PA level-shifter dir     pa_out_o     PA value     pa_dir_o  PA pin dir
//  lvl_pd_dir_o   PD level-shifter dir     pd_in_i      PD sample    pd_out_o  PD value
//  pd_dir_o       PD pin dir
module bbus_ctrl
  import bbus_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       pard_n_o,
  output logic       pawr_n_o,
  output logic       lvl_pa_dir_o,
  output logic [7:0] pa_out_o,
  output logic       pa_dir_o,
  output logic       lvl_pd_dir_o,
  input  logic [7:0] pd_in_i,
  output logic [7:0] pd_out_o,
  output logic       pd_dir_o
);

  if (SETUP_CYCLES == 0 || STROBE_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_bad_params
    $error("bbus_ctrl: SETUP_CYCLES, STROBE_CYCLES and HOLD_CYCLES must all be >= 1");
  end

  localparam int unsigned MaxCycles = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYCLES - 1);

  bbus_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       write_q;
  logic [7:0] pa_out_q;
  logic [7:0] pd_out_q;
  logic       pd_dir_q;
  logic       pard_n_q;
  logic       pawr_n_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;

  logic handshake;
  logic strobe_done;
  logic hold_done;

  assign req_ready_o = (state_q == StIdle) && !reset_i;
  assign handshake   = (state_q == StIdle) && req_valid_i;
  assign strobe_done = (state_q == StStrobe) && (cnt_q == '0);
  assign hold_done   = (state_q == StHold) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      pa_out_q    <= 8'h00;
      pd_out_q    <= 8'h00;
      pd_dir_q    <= PIN_DIR_INPUT;
      pard_n_q    <= 1'b1;
      pawr_n_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= hold_done;
      // Strobes are registered from the next state so they change only on clock edges.
      pard_n_q    <= !((state_d == StStrobe) && !write_q);
      pawr_n_q    <= !((state_d == StStrobe) && write_q);
      if (handshake) begin
        write_q  <= req_write_i;
        pa_out_q <= req_addr_i;
        if (req_write_i) begin
          pd_out_q <= req_wdata_i;
          pd_dir_q <= PIN_DIR_OUTPUT;
        end
      end
      // Sample PD on the edge where /PARD rises.
      if (strobe_done && !write_q) begin
        rsp_rdata_q <= pd_in_i;
      end
      if (hold_done) begin
        pd_dir_q <= PIN_DIR_INPUT;
      end
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign pard_n_o     = pard_n_q;
  assign pawr_n_o     = pawr_n_q;
  assign pa_out_o     = pa_out_q;
  assign pa_dir_o     = PIN_DIR_OUTPUT;
  assign lvl_pa_dir_o = LVL_DIR_OUTPUT;
  assign pd_out_o     = pd_out_q;
  assign pd_dir_o     = pd_dir_q;
  // Level shifter and pin always point the same way.
  assign lvl_pd_dir_o = (pd_dir_q == PIN_DIR_OUTPUT) ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;

endmodule
